// File: rtl/rect_fill_engine_if.sv
// Write-side bus between a command source and rect_fill_engine: command
// inputs, status flags and the frame-buffer write port.
interface rect_fill_engine_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          start;
  logic          clear;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] color;
  logic          busy;
  logic          done;
  logic          we;
  logic [XW-1:0] xw;
  logic [YW-1:0] yw;
  logic [CW-1:0] din;

  modport master (
    output start, clear, x0, x1, y0, y1, color,
    input  busy, done, we, xw, yw, din
  );

  modport slave (
    input  start, clear, x0, x1, y0, y1, color,
    output busy, done, we, xw, yw, din
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle / full-screen fill engine: normalizes and clips a command to the
// display, then streams one frame-buffer write per clock in raster order.
module rect_fill_engine #(
  parameter int H_RES = 160,
  parameter int V_RES = 120,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 3
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  rect_fill_engine_if.slave   bus
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t        state, state_next;

  logic          clr_q;
  logic          empty_q;
  logic [XW-1:0] x0_q, x1_q, xmin_q, xmax_q;
  logic [YW-1:0] y0_q, y1_q, ymax_q;
  logic [CW-1:0] color_q;

  logic [XW-1:0] s_xmin, s_xmax;
  logic [YW-1:0] s_ymin, s_ymax;
  logic          s_empty;
  logic          last_px;

  // Bounds of the latched command; only consumed while in SETUP.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    s_xmin = (x0_q < x1_q) ? x0_q : x1_q;
    s_xmax = (x0_q < x1_q) ? x1_q : x0_q;
    s_ymin = (y0_q < y1_q) ? y0_q : y1_q;
    s_ymax = (y0_q < y1_q) ? y1_q : y0_q;
    if (clr_q) begin
      s_xmin = '0;
      s_xmax = X_LAST;
      s_ymin = '0;
      s_ymax = Y_LAST;
    end
    if (s_xmax > X_LAST) s_xmax = X_LAST;
    if (s_ymax > Y_LAST) s_ymax = Y_LAST;
    s_empty = (s_xmin > X_LAST) || (s_ymin > Y_LAST);
  end

  // The write-address registers double as the fill cursor.
  assign last_px = (bus.xw == xmax_q) && (bus.yw == ymax_q);

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // An empty command spends a second cycle in SETUP so done lands two edges
  // after acceptance, matching the non-empty SETUP->DONE spacing.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (bus.start) state_next = SETUP;
      SETUP: if (!s_empty)  state_next = FILL;
             else if (empty_q) state_next = DONE;
      FILL:  if (last_px)   state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clr_q    <= 1'b0;
      empty_q  <= 1'b0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymax_q   <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.we   <= 1'b0;
      bus.xw   <= '0;
      bus.yw   <= '0;
      bus.din  <= '0;
    end else begin
      bus.busy <= (state_next == SETUP) || (state_next == FILL);
      bus.done <= (state_next == DONE);
      bus.we   <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          clr_q   <= bus.clear;
          x0_q    <= bus.x0;
          x1_q    <= bus.x1;
          y0_q    <= bus.y0;
          y1_q    <= bus.y1;
          color_q <= bus.color;
          empty_q <= 1'b0;
        end
        SETUP: if (!s_empty) begin
          xmin_q  <= s_xmin;
          xmax_q  <= s_xmax;
          ymax_q  <= s_ymax;
          bus.xw  <= s_xmin;
          bus.yw  <= s_ymin;
          bus.din <= color_q;
          bus.we  <= 1'b1;
        end else begin
          empty_q <= 1'b1;
        end
        FILL: if (!last_px) begin
          bus.we <= 1'b1;
          if (bus.xw < xmax_q) begin
            bus.xw <= bus.xw + 1'b1;
          end else begin
            bus.xw <= xmin_q;
            bus.yw <= bus.yw + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus random
// rectangles checked against a pixel-list reference model and address scoreboard.
module tb_rect_fill_engine;

  localparam int H_RES = 160;
  localparam int V_RES = 120;

  logic CLOCK_50;
  logic reset;

  rect_fill_engine_if #(.XW(8), .YW(7), .CW(3)) bus ();

  rect_fill_engine #(.H_RES(H_RES), .V_RES(V_RES), .XW(8), .YW(7), .CW(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_bad    = 0;
  int cnt[H_RES*V_RES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one command and follow it to completion. poke drives a second start
  // mid-fill; a start is also driven during the done cycle. Both must be ignored.
  task automatic run_cmd(input string name, input logic clr,
                         input logic [7:0] ax0, input logic [7:0] ax1,
                         input logic [6:0] ay0, input logic [6:0] ay1,
                         input logic [2:0] col, input bit poke);
    int xl, xh, yl, yh, n, idx, cyc, errs, bad_addr, done_cyc, want;
    bit seen_done, poke_en;
    logic [17:0] exp_q[$];
    logic [17:0] got;

    xl = (ax0 < ax1) ? int'(ax0) : int'(ax1);
    xh = (ax0 < ax1) ? int'(ax1) : int'(ax0);
    yl = (ay0 < ay1) ? int'(ay0) : int'(ay1);
    yh = (ay0 < ay1) ? int'(ay1) : int'(ay0);
    if (clr) begin xl = 0; xh = H_RES-1; yl = 0; yh = V_RES-1; end
    if (xh > H_RES-1) xh = H_RES-1;
    if (yh > V_RES-1) yh = V_RES-1;
    if (xl < H_RES && yl < V_RES)
      for (int y = yl; y <= yh; y++)
        for (int x = xl; x <= xh; x++)
          exp_q.push_back({8'(x), 7'(y), col});
    n = exp_q.size();
    poke_en = poke && (n >= 4);
    foreach (cnt[i]) cnt[i] = 0;

    @(negedge CLOCK_50);
    bus.clear = clr; bus.x0 = ax0; bus.x1 = ax1; bus.y0 = ay0; bus.y1 = ay1;
    bus.color = col; bus.start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.start = 1'b0;
    bus.clear = 1'($urandom); bus.x0 = 8'($urandom); bus.x1 = 8'($urandom);
    bus.y0 = 7'($urandom); bus.y1 = 7'($urandom); bus.color = 3'($urandom);
    @(negedge CLOCK_50);
    check({name, ":busy_setup"}, bus.busy, 1);
    check({name, ":we_setup"}, bus.we, 0);

    cyc = 0; idx = 0; errs = 0; seen_done = 0; done_cyc = -1;
    while (!seen_done && cyc < n + 8) begin
      @(negedge CLOCK_50);
      cyc++;
      bus.start = poke_en && (cyc == 3);
      if (bus.we) begin
        got = {bus.xw, bus.yw, bus.din};
        if (idx >= n || got !== exp_q[idx] || cyc != idx + 1) errs++;
        if (int'(bus.xw) < H_RES && int'(bus.yw) < V_RES)
          cnt[int'(bus.yw)*H_RES + int'(bus.xw)]++;
        idx++;
      end
      if (bus.done) begin
        seen_done = 1; done_cyc = cyc;
        if (bus.busy !== 1'b0 || bus.we !== 1'b0) errs++;
        bus.start = 1'b1;
      end else if (bus.busy !== 1'b1) begin
        errs++;
      end
    end
    check({name, ":done_seen"}, seen_done, 1);
    check({name, ":done_cycle"}, done_cyc, (n == 0) ? 2 : n + 1);
    check({name, ":write_count"}, idx, n);
    check({name, ":stream"}, errs, 0);

    bad_addr = 0;
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++) begin
        want = (n > 0 && x >= xl && x <= xh && y >= yl && y <= yh) ? 1 : 0;
        if (cnt[y*H_RES + x] != want) bad_addr++;
      end
    check({name, ":scoreboard"}, bad_addr, 0);

    @(negedge CLOCK_50);
    bus.start = 1'b0;
    check({name, ":done_pulse"}, bus.done, 0);
    check({name, ":start_in_done_ignored"}, bus.busy, 0);
  endtask

  // Reset lands on the 50th write of a clear; nothing may follow it.
  task automatic reset_mid_fill();
    int writes, cyc, stray;
    @(negedge CLOCK_50);
    bus.clear = 1'b1; bus.color = 3'd2; bus.start = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0;
    writes = 0; cyc = 0;
    while (writes < 50 && cyc < 200) begin
      @(negedge CLOCK_50);
      cyc++;
      if (bus.we) writes++;
    end
    check("rst:reached_50", writes, 50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rst:we", bus.we, 0);
    check("rst:busy", bus.busy, 0);
    check("rst:done", bus.done, 0);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      if (bus.we || bus.done || bus.busy) stray++;
    end
    check("rst:quiet_after", stray, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.clear = 1'b0; bus.color = '0;
    bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset:busy", bus.busy, 0);
    check("reset:done", bus.done, 0);
    check("reset:we", bus.we, 0);
    check("reset:xw", bus.xw, 0);
    check("reset:yw", bus.yw, 0);
    check("reset:din", bus.din, 0);
    reset = 1'b0;

    run_cmd("single",  1'b0,   5,   5,   7,   7, 3'd3, 1'b0);
    run_cmd("swapped", 1'b0,  12,  10,   4,   3, 3'd6, 1'b1);
    run_cmd("clip4",   1'b0, 158, 200, 118, 127, 3'd1, 1'b0);
    run_cmd("empty_x", 1'b0, 170, 180,  10,  20, 3'd4, 1'b0);
    run_cmd("empty_y", 1'b0,  10,  20, 125, 120, 3'd4, 1'b0);
    run_cmd("clear",   1'b1,  33,   7,  99,   2, 3'd5, 1'b1);

    reset_mid_fill();
    run_cmd("post_rst", 1'b0, 5, 5, 7, 7, 3'd3, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0)
        run_cmd("rand_edge", 1'b0,
                8'($urandom_range(140, 180)), 8'($urandom_range(140, 180)),
                7'($urandom_range(100, 127)), 7'($urandom_range(100, 127)),
                3'($urandom), 1'($urandom));
      else
        run_cmd("rand_low", 1'b0,
                8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                3'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
